// File: rtl/lfsr_rx_checker_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lfsr_rx_checker_if
// Groups the serial receive link and the checker status outputs of
// lfsr_rx_checker into one bundle.
//
// Signals:
//   seed          4      expected first word, sampled by the checker in reset
//   serial_in     1      serial data bit, LSB of each word first
//   serial_valid  1      serial_in carries a valid bit this cycle
//   word_out      4      last assembled word
//   word_valid    1      one-cycle pulse, word_out/match updated
//   match         1      last word equalled the expected LFSR value
//   locked        1      checker is locked onto the sequence
//   err_count     ERR_W  saturating count of mismatches seen while locked
//
// Modports:
//   master  the link side: drives seed and the serial stream, observes status
//   slave   the checker:   consumes the serial stream, drives status
// -----------------------------------------------------------------------------
interface lfsr_rx_checker_if #(
    parameter int ERR_W = 8
);
    logic [3:0]       seed;
    logic             serial_in;
    logic             serial_valid;
    logic [3:0]       word_out;
    logic             word_valid;
    logic             match;
    logic             locked;
    logic [ERR_W-1:0] err_count;

    modport master (
        output seed,
        output serial_in,
        output serial_valid,
        input  word_out,
        input  word_valid,
        input  match,
        input  locked,
        input  err_count
    );

    modport slave (
        input  seed,
        input  serial_in,
        input  serial_valid,
        output word_out,
        output word_valid,
        output match,
        output locked,
        output err_count
    );
endinterface

// File: rtl/lfsr_rx_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lfsr_rx_checker
// Receive-side checker for the LFSR serial link. Rebuilds 4-bit words from
// the 1-bit stream (LSB first, qualified by serial_valid), compares each word
// against a locally regenerated x^4+x^3+1 sequence, and reports per-word
// match, lock status and a saturating error count.
//
// Parameters:
//   ERR_W        width of the error counter
//   LOSS_THRESH  consecutive mismatches while locked that drop lock (1..7)
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-low reset
//   bus   lfsr_rx_checker_if slave modport (serial input, status outputs)
// -----------------------------------------------------------------------------
module lfsr_rx_checker #(
    parameter int ERR_W       = 8,
    parameter int LOSS_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_rx_checker_if.slave      bus
);

    localparam logic [0:0]       ST_UNLOCKED = 1'b0;
    localparam logic [0:0]       ST_LOCKED   = 1'b1;
    localparam logic [2:0]       LP_THRESH   = 3'(LOSS_THRESH);
    localparam logic [ERR_W-1:0] LP_ERR_MAX  = {ERR_W{1'b1}};

    // Sequence step of x^4+x^3+1; the all-zero state never appears.
    function automatic logic [3:0] lfsr_next(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    logic [1:0]       r_bit_cnt;
    logic [2:0]       r_shift;
    logic [3:0]       r_word_out;
    logic             r_word_valid;
    logic             r_match;
    logic [0:0]       r_state;
    logic [3:0]       r_expected;
    logic [2:0]       r_miss_cnt;
    logic [ERR_W-1:0] r_err_count;

    logic             w_word_done;
    logic [3:0]       w_word;
    logic             w_hit;
    logic [3:0]       w_seed_eff;
    logic [0:0]       w_state_nxt;
    logic [3:0]       w_expected_nxt;
    logic [2:0]       w_miss_nxt;
    logic [ERR_W-1:0] w_err_nxt;
    logic             w_match_nxt;

    // The bit arriving now is bit 3, so the complete word is formed from the
    // three stored bits plus the live input; no extra cycle of latency.
    assign w_word_done = bus.serial_valid && (r_bit_cnt == 2'd3);
    assign w_word      = {bus.serial_in, r_shift};
    assign w_hit       = (w_word == r_expected);

    // A zero seed would park the generator in its lock-up state.
    assign w_seed_eff  = (bus.seed == 4'd0) ? 4'd1 : bus.seed;

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_miss_nxt     = r_miss_cnt;
        w_err_nxt      = r_err_count;
        w_match_nxt    = r_match;

        if (w_word_done) begin
            w_match_nxt = w_hit;
            case (r_state)
                ST_UNLOCKED: begin
                    if (w_hit) begin
                        w_state_nxt    = ST_LOCKED;
                        w_expected_nxt = lfsr_next(w_word);
                        w_miss_nxt     = 3'd0;
                    end else if (w_word != 4'd0) begin
                        // Self-synchronise: trust the received word as the
                        // new sequence position. A zero word is not a valid
                        // LFSR state, so it cannot be adopted.
                        w_expected_nxt = lfsr_next(w_word);
                    end
                end
                ST_LOCKED: begin
                    // While locked the local generator free-runs; a bad
                    // word does not move our notion of sequence position.
                    w_expected_nxt = lfsr_next(r_expected);
                    if (w_hit) begin
                        w_miss_nxt = 3'd0;
                    end else begin
                        if (r_err_count != LP_ERR_MAX) begin
                            w_err_nxt = r_err_count + 1'b1;
                        end
                        if ((r_miss_cnt + 3'd1) == LP_THRESH) begin
                            w_state_nxt = ST_UNLOCKED;
                            w_miss_nxt  = 3'd0;
                        end else begin
                            w_miss_nxt = r_miss_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_UNLOCKED;
                    w_miss_nxt  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt    <= 2'd0;
            r_shift      <= 3'd0;
            r_word_out   <= 4'd0;
            r_word_valid <= 1'b0;
            r_match      <= 1'b0;
            r_state      <= ST_UNLOCKED;
            r_expected   <= w_seed_eff;
            r_miss_cnt   <= 3'd0;
            r_err_count  <= '0;
        end else begin
            r_word_valid <= 1'b0;

            // bit_cnt and the partial word simply hold while serial_valid
            // is low, however long the gap.
            if (bus.serial_valid) begin
                r_bit_cnt <= r_bit_cnt + 2'd1;
                case (r_bit_cnt)
                    2'd0:    r_shift[0] <= bus.serial_in;
                    2'd1:    r_shift[1] <= bus.serial_in;
                    2'd2:    r_shift[2] <= bus.serial_in;
                    default: r_shift    <= 3'd0;
                endcase
            end

            if (w_word_done) begin
                r_word_out   <= w_word;
                r_word_valid <= 1'b1;
                r_match      <= w_match_nxt;
                r_state      <= w_state_nxt;
                r_expected   <= w_expected_nxt;
                r_miss_cnt   <= w_miss_nxt;
                r_err_count  <= w_err_nxt;
            end
        end
    end

    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.match      = r_match;
    assign bus.locked     = (r_state == ST_LOCKED);
    assign bus.err_count  = r_err_count;

endmodule

// File: tb/tb_lfsr_rx_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_lfsr_rx_checker
// Self-checking bench for lfsr_rx_checker. A driver serialises words onto the
// link and, as each word's last bit goes out, pushes the expected response
// (word, match, locked, err_count, arrival cycle) from a sequence-table model
// into a scoreboard queue. A monitor pops and compares on every word_valid.
// -----------------------------------------------------------------------------
module tb_lfsr_rx_checker;

    localparam int ERR_W   = 8;
    localparam int LOSS    = 3;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    typedef struct {
        logic [3:0] word;
        logic       match;
        logic       locked;
        int         err;
        longint     cyc;
    } exp_t;

    logic clk;
    logic rst;

    lfsr_rx_checker_if #(.ERR_W(ERR_W)) bus ();

    lfsr_rx_checker #(
        .ERR_W       (ERR_W),
        .LOSS_THRESH (LOSS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       scoreQ[$];
    int         tests = 0;
    int         fails = 0;
    longint     cyc   = 0;

    // The full 15-word period laid out as a table; the model tracks a
    // position in this table rather than stepping a register.
    logic [3:0] lfsrSeq[15];
    int         posOf[16];

    bit         mLocked;
    int         mIdx;
    int         mMiss;
    int         mErr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic modelReset(input logic [3:0] s);
        mLocked = 1'b0;
        mIdx    = posOf[(s == 4'd0) ? 1 : int'(s)];
        mMiss   = 0;
        mErr    = 0;
    endtask

    task automatic modelWord(input logic [3:0] w, output exp_t e);
        logic [3:0] want;
        want    = lfsrSeq[mIdx];
        e.word  = w;
        e.match = (w == want);
        if (!mLocked) begin
            if (w == want) begin
                mLocked = 1'b1;
                mIdx    = (mIdx + 1) % 15;
                mMiss   = 0;
            end else if (w != 4'd0) begin
                mIdx = (posOf[int'(w)] + 1) % 15;
            end
        end else begin
            mIdx = (mIdx + 1) % 15;
            if (w == want) begin
                mMiss = 0;
            end else begin
                if (mErr < ERR_MAX) mErr++;
                mMiss++;
                if (mMiss == LOSS) begin
                    mLocked = 1'b0;
                    mMiss   = 0;
                end
            end
        end
        e.locked = mLocked;
        e.err    = mErr;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.word_valid === 1'b1) begin
            checkOutput("pulse_expected", (scoreQ.size() > 0) ? 1 : 0, 1);
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput("word_out",   bus.word_out,  e.word);
                checkOutput("match",      bus.match,     e.match);
                checkOutput("locked",     bus.locked,    e.locked);
                checkOutput("err_count",  bus.err_count, e.err);
                checkOutput("pulse_cycle", cyc,          e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.serial_valid = 1'b0;
            bus.serial_in    = 1'($urandom);
        end
    endtask

    task automatic resetDut(input logic [3:0] s);
        @(negedge clk);
        bus.serial_valid = 1'b0;
        bus.serial_in    = 1'b0;
        bus.seed         = s;
        rst              = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        bus.seed = 4'($urandom);
        modelReset(s);
        checkOutput("rst_word_out",   bus.word_out,   0);
        checkOutput("rst_word_valid", bus.word_valid, 0);
        checkOutput("rst_match",      bus.match,      0);
        checkOutput("rst_locked",     bus.locked,     0);
        checkOutput("rst_err_count",  bus.err_count,  0);
    endtask

    // Sends one word LSB first; gapLen idle cycles are inserted just before
    // bit gapPos.
    task automatic applyStimulus(input logic [3:0] w, input int gapPos, input int gapLen);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == gapPos) idle(gapLen);
            @(negedge clk);
            bus.serial_valid = 1'b1;
            bus.serial_in    = w[i];
            if (i == 3) begin
                modelWord(w, e);
                e.cyc = cyc + 1;
                scoreQ.push_back(e);
            end
        end
    endtask

    task automatic sendPartial(input logic [3:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.serial_valid = 1'b1;
            bus.serial_in    = w[i];
        end
    endtask

    initial begin
        int         q;
        logic [3:0] w;
        int         r;
        int         gp;
        int         gl;

        q = 1;
        for (int i = 0; i < 15; i++) begin
            lfsrSeq[i] = 4'(q);
            posOf[q]   = i;
            q = ((q << 1) & 15) | (((q >> 3) ^ (q >> 2)) & 1);
        end
        posOf[0] = 0;

        rst              = 1'b0;
        bus.seed         = 4'd0;
        bus.serial_in    = 1'b0;
        bus.serial_valid = 1'b0;
        modelReset(4'd0);

        // Clean locked stream, back to back.
        resetDut(4'b1001);
        applyStimulus(4'b1001, 4, 0);
        applyStimulus(4'b0011, 4, 0);
        applyStimulus(4'b0110, 4, 0);
        applyStimulus(4'b1101, 4, 0);
        idle(3);

        // Valid gap in the middle of the second word.
        resetDut(4'b1001);
        applyStimulus(4'b1001, 4, 0);
        applyStimulus(4'b0011, 2, 3);
        applyStimulus(4'b0110, 4, 0);
        applyStimulus(4'b1101, 4, 0);
        idle(3);

        // Single bad word while locked.
        resetDut(4'b1001);
        applyStimulus(4'b1001, 4, 0);
        applyStimulus(4'b0011, 4, 0);
        applyStimulus(4'b0111, 4, 0);
        applyStimulus(4'b1101, 4, 0);
        idle(3);

        // Loss of lock, then resynchronisation by adoption.
        resetDut(4'b1001);
        applyStimulus(4'b1001, 4, 0);
        applyStimulus(4'b0000, 4, 0);
        applyStimulus(4'b0000, 4, 0);
        applyStimulus(4'b0000, 4, 0);
        applyStimulus(4'b0101, 4, 0);
        applyStimulus(4'b1011, 4, 0);
        idle(3);

        // Zero seed maps to 0001; then drive the error counter to saturation.
        resetDut(4'b0000);
        applyStimulus(4'b0001, 4, 0);
        for (int n = 0; n < 400; n++) begin
            if (mLocked) w = lfsrSeq[mIdx] ^ 4'($urandom_range(1, 15));
            else         w = lfsrSeq[mIdx];
            applyStimulus(w, 4, 0);
        end
        idle(3);
        checkOutput("err_saturated", bus.err_count, ERR_MAX);

        // Reset in mid-word discards the partial bits.
        resetDut(4'b1001);
        sendPartial(4'b0110, 2);
        resetDut(4'b1001);
        applyStimulus(4'b1001, 4, 0);
        idle(3);

        // Randomised traffic with gaps, occasional resets, seed wiggling.
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) resetDut(4'($urandom));
            r = $urandom_range(0, 9);
            if (r < 6)      w = lfsrSeq[mIdx];
            else if (r < 9) w = 4'($urandom);
            else            w = 4'd0;
            gp = $urandom_range(0, 3);
            gl = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 3) : 0;
            bus.seed = 4'($urandom);
            applyStimulus(w, gp, gl);
        end
        idle(8);
        checkOutput("queue_drained", scoreQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lfsr_rx_checker.md
# lfsr_rx_checker

Receive-side counterpart of the LFSR serial transmitter. Deserializes the 1-bit LFSR stream (LSB first, 4 bits per word, qualified by a valid strobe) back into 4-bit words. Checks each word against a locally regenerated LFSR sequence and reports per-word match, lock status and a saturating error count. Sits at the far end of the serial link as the link/sequence checker.

## Interface
- ERR_W, 8, width of error counter
- LOSS_THRESH, 3, consecutive mismatches in LOCKED that force UNLOCKED (1..7)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-low reset
- seed  input  4  expected first word; sampled only while rst is low
- serial_in  input  1  serial data bit
- serial_valid  input  1  serial_in is valid this cycle
- word_out  output  4  last assembled word
- word_valid  output  1  1-cycle pulse: word_out updated
- match  output  1  word_out equalled expected value (valid with word_valid)
- locked  output  1  checker FSM in LOCKED
- err_count  output  ERR_W  mismatches counted while LOCKED, saturating

## Operation
- LFSR step: next(q) = {q[2:0], q[3]^q[2]} (x^4+x^3+1, period 15, zero state excluded).
- Reset (rst=0 at edge): bit_cnt=0, shift reg=0, word_out=0, word_valid=0, match=0, locked=0, err_count=0, miss_cnt=0, FSM=UNLOCKED, expected = (seed==0) ? 4'b0001 : seed. Reset wins over all other events.
- Deserializer: each edge with serial_valid=1 writes serial_in to bit position bit_cnt (first bit -> bit 0), bit_cnt increments mod 4. serial_valid=0 holds bit_cnt and partial word indefinitely (no timeout).
- Word complete: edge sampling bit 3 loads word_out, pulses word_valid, updates match/FSM/expected/counters. word_valid=0 on every other cycle; match holds its last value between pulses.
- FSM UNLOCKED, on word w:
  - w==expected: match=1, go LOCKED, expected=next(w), miss_cnt=0.
  - w!=expected, w!=0: match=0, stay, expected=next(w) (self-sync: adopt received word).
  - w==0: match=0, stay, expected unchanged.
  - err_count never changes in UNLOCKED.
- FSM LOCKED, on word w:
  - w==expected: match=1, expected=next(expected), miss_cnt=0.
  - w!=expected: match=0, expected=next(expected), err_count+1 (holds at 2^ERR_W-1), miss_cnt+1. If miss_cnt reaches LOSS_THRESH: go UNLOCKED, miss_cnt=0.
- locked reflects FSM state, registered.

## Timing
- Latency: word_out/word_valid/match/locked/err_count all change at the same edge that samples the 4th valid bit; visible the following cycle.
- Back-to-back words with continuous serial_valid: one word_valid pulse every 4 cycles, no bubble.
- Max throughput 1 bit/cycle; no backpressure, no ready signal.
- Reset mid-word discards partial bits; first word after reset is compared against seed (or 0001).
- seed changes outside reset have no effect.

## Test plan
- Seed 1001, reset, stream words 1001,0011,0110,1101 LSB first, serial_valid continuous -> 4 word_valid pulses 4 cycles apart, match=1 each, locked=1 from first pulse, err_count=0.
- Same stream with serial_valid low 3 cycles between bit 1 and bit 2 of word 2 -> word_out=0011, match=1, pulse delayed 3 cycles, no extra pulses.
- Locked at seed 1001, send 1001,0011,0111,1101 -> third word match=0, err_count=1, locked stays 1, fourth word match=1.
- Locked, send 3 consecutive bad words (0000,0000,0000 after 1001) -> err_count=3, locked drops at 3rd pulse; then 0101,1011 -> 0101 mismatch/adopted, 1011 match, locked=1, err_count stays 3.
- Seed 0000, reset, first word 0001 -> match=1, locked=1; force 300 mismatching LOCKED words with LOSS_THRESH=7 reloc cycles -> err_count saturates at 255.
- Shift 2 bits of a word, pulse rst low 1 cycle, then send 4 bits of seed word -> single word_valid, word_out=seed, match=1, no spurious pulse.
